clarke_inv_arbiter: RTL

//  Shares one inverse-Clarke engine (64-bit AXI-Stream in/out, one transaction in flight) between two requesters.

---
 rtl/clarke_inv_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/clarke_inv_arbiter.sv
// Two-requester round-robin front end for a shared inverse-Clarke engine.
// One command in flight; results are routed back to the issuing requester.
module clarke_inv_arbiter #(
    parameter int DW          = 64,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic          clk,
    input  logic          reset,

    input  logic [DW-1:0] s0_axis_tdata,
    input  logic          s0_axis_tvalid,
    output logic          s0_axis_tready,

    input  logic [DW-1:0] s1_axis_tdata,
    input  logic          s1_axis_tvalid,
    output logic          s1_axis_tready,

    output logic [DW-1:0] e_in_tdata,
    output logic          e_in_tvalid,
    input  logic          e_in_tready,

    input  logic [DW-1:0] e_out_tdata,
    input  logic          e_out_tvalid,
    output logic          e_out_tready,

    output logic [DW-1:0] m0_axis_tdata,
    output logic          m0_axis_tvalid,
    input  logic          m0_axis_tready,

    output logic [DW-1:0] m1_axis_tdata,
    output logic          m1_axis_tvalid,
    input  logic          m1_axis_tready,

    output logic          timeout_err,
    output logic          stale_drop,
    output logic          err_sticky,
    output logic [15:0]   txn_cnt0,
    output logic [15:0]   txn_cnt1
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;
    logic [DW-1:0] cmd_q, cmd_d;
    logic [DW-1:0] rsp_q, rsp_d;
    logic          chan_q, chan_d;
    logic          last_grant_q, last_grant_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   txn0_q, txn0_d;
    logic [15:0]   txn1_q, txn1_d;
    logic          timeout_q, timeout_d;
    logic          stale_q, stale_d;
    logic          sticky_q, sticky_d;

    logic          gnt;
    logic          s_hs;
    logic          m_hs;
    logic          wd_expired;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            rsp_q        <= '0;
            chan_q       <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            txn0_q       <= '0;
            txn1_q       <= '0;
            timeout_q    <= 1'b0;
            stale_q      <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            rsp_q        <= rsp_d;
            chan_q       <= chan_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            txn0_q       <= txn0_d;
            txn1_q       <= txn1_d;
            timeout_q    <= timeout_d;
            stale_q      <= stale_d;
            sticky_q     <= sticky_d;
        end
    end

    assign wd_expired = (cnt_q == CNT_LAST);
    assign s_hs       = s0_axis_tready | s1_axis_tready;
    assign m_hs       = (state_q == DELIVER) &
                        (chan_q ? m1_axis_tready : m0_axis_tready);

    // Next-state logic; a result in the last watchdog cycle beats the abort
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (s_hs) state_d = ISSUE;
            end
            ISSUE: begin
                if (e_in_tready) state_d = WAIT;
            end
            WAIT: begin
                if (e_out_tvalid)    state_d = DELIVER;
                else if (wd_expired) state_d = IDLE;
            end
            DELIVER: begin
                if (m_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic; grant is re-evaluated every IDLE cycle
    always_comb begin
        gnt = (s0_axis_tvalid & s1_axis_tvalid) ? ~last_grant_q
                                                : s1_axis_tvalid;

        s0_axis_tready = ~reset & (state_q == IDLE) &
                         s0_axis_tvalid & ~gnt;
        s1_axis_tready = ~reset & (state_q == IDLE) &
                         s1_axis_tvalid & gnt;

        e_in_tvalid    = (state_q == ISSUE);
        e_out_tready   = ~reset & (state_q != DELIVER);

        m0_axis_tvalid = (state_q == DELIVER) & ~chan_q;
        m1_axis_tvalid = (state_q == DELIVER) & chan_q;
    end

    // Datapath, counters and event pulses
    always_comb begin
        cmd_d        = cmd_q;
        rsp_d        = rsp_q;
        chan_d       = chan_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        txn0_d       = txn0_q;
        txn1_d       = txn1_q;
        sticky_d     = sticky_q;
        timeout_d    = 1'b0;
        stale_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                stale_d = e_out_tvalid;
                if (s_hs) begin
                    cmd_d        = gnt ? s1_axis_tdata : s0_axis_tdata;
                    chan_d       = gnt;
                    last_grant_d = gnt;
                end
            end
            ISSUE: begin
                stale_d = e_out_tvalid;
                if (e_in_tready) cnt_d = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (e_out_tvalid) begin
                    rsp_d = e_out_tdata;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    sticky_d  = 1'b1;
                end
            end
            DELIVER: begin
                if (m_hs) begin
                    if (chan_q) txn1_d = txn1_q + 16'd1;
                    else        txn0_d = txn0_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    assign e_in_tdata    = cmd_q;
    assign m0_axis_tdata = rsp_q;
    assign m1_axis_tdata = rsp_q;
    assign timeout_err   = timeout_q;
    assign stale_drop    = stale_q;
    assign err_sticky    = sticky_q;
    assign txn_cnt0      = txn0_q;
    assign txn_cnt1      = txn1_q;

endmodule
